// File: rtl/led_sweep_monitor.sv
// Decodes a knight-rider LED bus back into position, direction, step period and PWM duty.
// Pattern violations (multi-lit, jumps, mid-sweep reversal) raise a sticky error flag.
module led_sweep_monitor #(
   parameter int OUT_WIDTH = 8,
   parameter int WIN       = 16,
   parameter int PER_W     = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [OUT_WIDTH-1:0]         leds,
   input  logic                         err_clear,
   output logic [$clog2(OUT_WIDTH)-1:0] pos,
   output logic                         pos_valid,
   output logic                         dir,
   output logic                         step_pulse,
   output logic [PER_W-1:0]             step_period,
   output logic                         per_valid,
   output logic [$clog2(WIN):0]         duty,
   output logic                         err
);

   localparam int POS_W  = $clog2(OUT_WIDTH);
   localparam int WC_W   = $clog2(WIN);
   localparam int DUTY_W = WC_W + 1;

   localparam logic [WC_W-1:0]  EOW_CNT  = WC_W'(WIN - 1);
   localparam logic [PER_W-1:0] PER_MAX  = '1;
   localparam logic [POS_W-1:0] LAST_POS = POS_W'(OUT_WIDTH - 1);
   localparam logic [POS_W:0]   ONE_EXT  = (POS_W + 1)'(1);

   logic [WC_W-1:0]      wcnt_q, wcnt_d;
   logic [OUT_WIDTH-1:0] lit_acc_q, lit_acc_d;
   logic [DUTY_W-1:0]    on_cnt_q, on_cnt_d;
   logic [PER_W-1:0]     per_cnt_q, per_cnt_d;
   logic [1:0]           nsteps_q, nsteps_d;
   logic [POS_W-1:0]     pos_q, pos_d;
   logic                 pos_valid_q, pos_valid_d;
   logic                 dir_q, dir_d;
   logic                 step_pulse_q, step_pulse_d;
   logic [PER_W-1:0]     step_period_q, step_period_d;
   logic                 per_valid_q, per_valid_d;
   logic [DUTY_W-1:0]    duty_q, duty_d;
   logic                 err_q, err_d;

   logic                 eow;
   logic [OUT_WIDTH-1:0] lit_all;
   logic [DUTY_W-1:0]    duty_all;
   logic                 multi;
   logic [POS_W-1:0]     p_idx;
   logic [POS_W:0]       p_ext;
   logic [POS_W:0]       pos_ext;
   logic                 up_step;
   logic                 down_step;
   logic [PER_W-1:0]     per_cnt_inc;
   logic                 err_set;

   // The EOW cycle's own sample is folded in before evaluation.
   assign eow         = (wcnt_q == EOW_CNT);
   assign lit_all     = lit_acc_q | leds;
   assign duty_all    = on_cnt_q + DUTY_W'(|leds);
   assign multi       = ((lit_all & (lit_all - OUT_WIDTH'(1))) != '0);
   assign per_cnt_inc = (per_cnt_q == PER_MAX) ? PER_MAX : per_cnt_q + PER_W'(1);
   assign p_ext       = {1'b0, p_idx};
   assign pos_ext     = {1'b0, pos_q};
   assign up_step     = (p_ext == pos_ext + ONE_EXT);
   assign down_step   = (pos_ext == p_ext + ONE_EXT);

   always_comb begin
      p_idx = '0;
      for (int i = 0; i < OUT_WIDTH; i++) begin
         if (lit_all[i]) p_idx = POS_W'(i);
      end
   end

   always_comb begin
      wcnt_d        = wcnt_q + WC_W'(1);
      lit_acc_d     = lit_all;
      on_cnt_d      = duty_all;
      per_cnt_d     = per_cnt_inc;
      nsteps_d      = nsteps_q;
      pos_d         = pos_q;
      pos_valid_d   = pos_valid_q;
      dir_d         = dir_q;
      step_pulse_d  = 1'b0;
      step_period_d = step_period_q;
      per_valid_d   = per_valid_q;
      duty_d        = duty_q;
      err_set       = 1'b0;

      if (eow) begin
         lit_acc_d = '0;
         on_cnt_d  = '0;
         duty_d    = duty_all;
         if (lit_all != '0) begin
            if (multi) begin
               err_set = 1'b1;
            end else if (!pos_valid_q) begin
               pos_d       = p_idx;
               pos_valid_d = 1'b1;
            end else if (p_idx != pos_q) begin
               if (!(up_step || down_step)) begin
                  // Jump: resynchronise and forget direction history.
                  err_set     = 1'b1;
                  pos_d       = p_idx;
                  nsteps_d    = 2'd0;
                  per_valid_d = 1'b0;
               end else begin
                  pos_d        = p_idx;
                  step_pulse_d = 1'b1;
                  dir_d        = up_step;
                  per_cnt_d    = '0;
                  nsteps_d     = (nsteps_q == 2'd2) ? 2'd2 : nsteps_q + 2'd1;
                  if (nsteps_q != 2'd0) begin
                     step_period_d = per_cnt_inc;
                     per_valid_d   = 1'b1;
                     if ((up_step != dir_q) && (pos_q != '0) && (pos_q != LAST_POS))
                        err_set = 1'b1;
                  end
               end
            end
         end
      end

      err_d = err_set | (err_q & ~err_clear);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wcnt_q        <= '0;
         lit_acc_q     <= '0;
         on_cnt_q      <= '0;
         per_cnt_q     <= '0;
         nsteps_q      <= '0;
         pos_q         <= '0;
         pos_valid_q   <= 1'b0;
         dir_q         <= 1'b0;
         step_pulse_q  <= 1'b0;
         step_period_q <= '0;
         per_valid_q   <= 1'b0;
         duty_q        <= '0;
         err_q         <= 1'b0;
      end else begin
         wcnt_q        <= wcnt_d;
         lit_acc_q     <= lit_acc_d;
         on_cnt_q      <= on_cnt_d;
         per_cnt_q     <= per_cnt_d;
         nsteps_q      <= nsteps_d;
         pos_q         <= pos_d;
         pos_valid_q   <= pos_valid_d;
         dir_q         <= dir_d;
         step_pulse_q  <= step_pulse_d;
         step_period_q <= step_period_d;
         per_valid_q   <= per_valid_d;
         duty_q        <= duty_d;
         err_q         <= err_d;
      end
   end

   assign pos         = pos_q;
   assign pos_valid   = pos_valid_q;
   assign dir         = dir_q;
   assign step_pulse  = step_pulse_q;
   assign step_period = step_period_q;
   assign per_valid   = per_valid_q;
   assign duty        = duty_q;
   assign err         = err_q;

endmodule

// File: tb/tb_led_sweep_monitor.sv
// Scoreboard bench: stimulus pushes per-window expectations, a negedge monitor pops and compares
// them after each window closes. A second instance with PER_W=4 checks period saturation.
module tb_led_sweep_monitor;

   localparam int WIN = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        err_clear;
   logic [7:0]  leds;

   logic [2:0]  pos;
   logic        pos_valid, dir, step_pulse, per_valid, err;
   logic [15:0] step_period;
   logic [4:0]  duty;

   logic [2:0]  pos4;
   logic        pos_valid4, dir4, step_pulse4, per_valid4, err4;
   logic [3:0]  step_period4;
   logic [4:0]  duty4;

   typedef struct packed {
      logic [2:0]  pos;
      logic        pv;
      logic        dir;
      logic        sp;
      logic [15:0] per;
      logic        perv;
      logic [4:0]  duty;
      logic        err;
      logic [3:0]  per4;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   tb_cyc = 0;

   led_sweep_monitor #(.OUT_WIDTH(8), .WIN(WIN), .PER_W(16)) dut (
      .clk(clk), .reset(reset), .leds(leds), .err_clear(err_clear),
      .pos(pos), .pos_valid(pos_valid), .dir(dir), .step_pulse(step_pulse),
      .step_period(step_period), .per_valid(per_valid), .duty(duty), .err(err)
   );

   led_sweep_monitor #(.OUT_WIDTH(8), .WIN(WIN), .PER_W(4)) dut_sat (
      .clk(clk), .reset(reset), .leds(leds), .err_clear(err_clear),
      .pos(pos4), .pos_valid(pos_valid4), .dir(dir4), .step_pulse(step_pulse4),
      .step_period(step_period4), .per_valid(per_valid4), .duty(duty4), .err(err4)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge reset) begin
      if (reset) tb_cyc <= 0;
      else       tb_cyc <= tb_cyc + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t mk(input int p, input int pv, input int d, input int sp, input int per,
                               input int perv, input int du, input int er, input int per4);
      exp_t e;
      e.pos  = 3'(p);
      e.pv   = 1'(pv);
      e.dir  = 1'(d);
      e.sp   = 1'(sp);
      e.per  = 16'(per);
      e.perv = 1'(perv);
      e.duty = 5'(du);
      e.err  = 1'(er);
      e.per4 = 4'(per4);
      return e;
   endfunction

   // Outputs change only on the edge closing a window; step_pulse must be low otherwise.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && tb_cyc != 0) begin
            if (tb_cyc % WIN == 0) begin
               if (sb_q.size() != 0) begin
                  e = sb_q.pop_front();
                  checkOutput("pos",         32'(pos),          32'(e.pos));
                  checkOutput("pos_valid",   32'(pos_valid),    32'(e.pv));
                  checkOutput("dir",         32'(dir),          32'(e.dir));
                  checkOutput("step_pulse",  32'(step_pulse),   32'(e.sp));
                  checkOutput("step_period", 32'(step_period),  32'(e.per));
                  checkOutput("per_valid",   32'(per_valid),    32'(e.perv));
                  checkOutput("duty",        32'(duty),         32'(e.duty));
                  checkOutput("err",         32'(err),          32'(e.err));
                  checkOutput("sat_period",  32'(step_period4), 32'(e.per4));
               end
            end else begin
               checkOutput("step_pulse_idle", 32'(step_pulse), 32'd0);
            end
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] pat, input int on_cycles, input int clr_at,
                                input exp_t e);
      sb_q.push_back(e);
      for (int i = 0; i < WIN; i++) begin
         leds      = (i < on_cycles) ? pat : 8'h00;
         err_clear = (i == clr_at);
         @(posedge clk);
         #1;
      end
      err_clear = 1'b0;
   endtask

   task automatic holdWindows(input logic [7:0] pat, input int n, input exp_t e);
      exp_t e2;
      applyStimulus(pat, WIN, -1, e);
      e2    = e;
      e2.sp = 1'b0;
      for (int i = 1; i < n; i++) applyStimulus(pat, WIN, -1, e2);
   endtask

   task automatic doReset();
      @(negedge clk);
      #1;
      reset     = 1'b1;
      leds      = 8'h00;
      err_clear = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] pat;
      reset     = 1'b1;
      leds      = 8'h00;
      err_clear = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;

      // Upward sweep, 64 clocks per position, then bounce off the top end.
      holdWindows(8'h01, 4, mk(0, 1, 0, 0, 0, 0, 16, 0, 0));
      holdWindows(8'h02, 4, mk(1, 1, 1, 1, 0, 0, 16, 0, 0));
      for (int k = 2; k < 8; k++) begin
         pat = 8'h01 << k;
         holdWindows(pat, 4, mk(k, 1, 1, 1, 64, 1, 16, 0, 15));
      end
      holdWindows(8'h40, 1, mk(6, 1, 0, 1, 64, 1, 16, 0, 15));

      // Asynchronous reset in the middle of a window.
      leds = 8'h10;
      repeat (8) begin
         @(posedge clk);
         #1;
      end
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rst_pos",         32'(pos),          32'd0);
      checkOutput("rst_pos_valid",   32'(pos_valid),    32'd0);
      checkOutput("rst_dir",         32'(dir),          32'd0);
      checkOutput("rst_step_pulse",  32'(step_pulse),   32'd0);
      checkOutput("rst_step_period", 32'(step_period),  32'd0);
      checkOutput("rst_per_valid",   32'(per_valid),    32'd0);
      checkOutput("rst_duty",        32'(duty),         32'd0);
      checkOutput("rst_err",         32'(err),          32'd0);
      checkOutput("rst_sat_period",  32'(step_period4), 32'd0);
      @(posedge clk);
      #1;
      leds = 8'h01;
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Jump, clear, reversal mid-sweep, and clear colliding with a multi-lit window.
      applyStimulus(8'h01, WIN, -1, mk(0, 1, 0, 0, 0, 0, 16, 0, 0));
      applyStimulus(8'h04, WIN, -1, mk(2, 1, 0, 0, 0, 0, 16, 1, 0));
      applyStimulus(8'h04, WIN,  3, mk(2, 1, 0, 0, 0, 0, 16, 0, 0));
      applyStimulus(8'h08, WIN, -1, mk(3, 1, 1, 1, 0, 0, 16, 0, 0));
      applyStimulus(8'h04, WIN, -1, mk(2, 1, 0, 1, 16, 1, 16, 1, 15));
      applyStimulus(8'h04, WIN,  0, mk(2, 1, 0, 0, 16, 1, 16, 0, 15));
      applyStimulus(8'h18, WIN, 15, mk(2, 1, 0, 0, 16, 1, 16, 1, 15));

      // PWM-dimmed LED, a dark window, then 32-clock steps for saturation.
      doReset();
      applyStimulus(8'h10, 4, -1, mk(4, 1, 0, 0, 0, 0, 4, 0, 0));
      applyStimulus(8'h10, 4, -1, mk(4, 1, 0, 0, 0, 0, 4, 0, 0));
      applyStimulus(8'h10, 0, -1, mk(4, 1, 0, 0, 0, 0, 0, 0, 0));
      holdWindows(8'h20, 2, mk(5, 1, 1, 1, 0, 0, 16, 0, 0));
      holdWindows(8'h40, 2, mk(6, 1, 1, 1, 32, 1, 16, 0, 15));
      holdWindows(8'h80, 2, mk(7, 1, 1, 1, 32, 1, 16, 0, 15));

      @(negedge clk);
      #1;
      checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/led_sweep_monitor.md
Name: led_sweep_monitor

Overview:
- Observes the 8-bit knight-rider LED bus from the LED side and decodes it back into state: lit position, sweep direction, step period and PWM duty.
- Flags illegal patterns: more than one lit LED, position jumps, and reversal away from an end.
- Used as an on-chip self-check and as the bench scoreboard front-end.
- All outputs are registered.

Parameters:
- OUT_WIDTH, 8, width of the observed LED bus (≥2).
- WIN, 16, observation window in clocks. Must be a power of 2 and ≥ the PWM period so that a dimmed LED is seen at least once per window.
- PER_W, 16, width of step_period; counter saturates.

Ports:
- clk  in  1  system clock (6 kHz nominal).
- reset  in  1  asynchronous, active-high; clears all state.
- leds  in  OUT_WIDTH  observed LED bus.
- err_clear  in  1  synchronous clear of sticky err.
- pos  out  clog2(OUT_WIDTH)  index of the lit LED.
- pos_valid  out  1  pos has been established at least once.
- dir  out  1  1 = moving toward MSB, 0 = toward LSB.
- step_pulse  out  1  one-cycle strobe, position changed.
- step_period  out  PER_W  clocks between the last two steps.
- per_valid  out  1  step_period holds a real measurement.
- duty  out  clog2(WIN)+1  cycles in the last window with any LED high (0..WIN).
- err  out  1  sticky pattern-violation flag.

Behaviour:
- Reset (async, immediate): all outputs and internal state go to 0, including wcnt, the accumulators, per_cnt and nsteps.
- Window counter wcnt counts 0..WIN-1 free-running and wraps. A window is WIN clocks; the last cycle is wcnt==WIN-1 ("EOW").
- Each cycle: lit_acc |= leds; on_cnt += (leds!=0).
- At EOW, evaluate using L = lit_acc|leds and D = on_cnt+(leds!=0), i.e. including the EOW cycle. Clear lit_acc and on_cnt at the same edge.
- All registered outputs update at the edge closing EOW. step_pulse is high only for the cycle after that edge.
- duty <= D every EOW.
- Evaluation of L at EOW, in priority order:
  - DARK (L==0): pos, dir and pos_valid hold. No step, no error.
  - MULTI (more than one bit set): err<=1. pos and dir hold.
  - ONE-HOT, index p:
    - If pos_valid==0: pos<=p, pos_valid<=1. No step.
    - Else if p==pos: no change.
    - Else if |p−pos|≠1: err<=1. pos<=p (resynchronise). No step pulse. Direction history is cleared (nsteps<=0, per_valid<=0).
    - Else (legal step): pos<=p, step_pulse<=1, and:
      - newdir = (p>pos).
      - If nsteps≥1, newdir≠dir, and old pos is neither 0 nor OUT_WIDTH-1: err<=1 (mid-sweep reversal).
      - dir<=newdir.
      - nsteps saturates at 2.
- Period measurement:
  - per_cnt increments every clock, saturating at 2^PER_W−1.
  - On a legal step edge: if nsteps≥1, step_period<=per_cnt+1 (saturating) and per_valid<=1. per_cnt<=0.
  - The first legal step after pos_valid, or after a jump, only restarts per_cnt.
  - Steps are only detected at EOW, so step_period is a multiple of WIN whenever the input period is.
- err:
  - Set by any violation above.
  - Cleared by err_clear==1 at a clock edge.
  - A set in the same cycle as err_clear wins, so err stays 1.
- leds is assumed synchronous to clk. No synchroniser inside.

Test Plan:
- Reset: assert reset mid-window with leds=0x10 → all outputs 0 immediately. Deassert with leds=0x01 held for 16 clocks → pos=0, pos_valid=1, dir=0, err=0, duty=16.
- Upward sweep: 0x01,0x02,0x04, each held 64 clocks, window-aligned.
  - First step: step_pulse once, pos=1, dir=1, per_valid=0.
  - Second step: pos=2, step_period=64, per_valid=1.
- Bounce and reversal:
  - Sweep to 0x80 then 0x40 → dir=0, err=0.
  - Separately, 0x04→0x08→0x04 → err=1 (reversal at pos 3).
- Jump and clear:
  - 0x01→0x04 → err=1, pos=2, no step_pulse, per_valid=0.
  - err_clear for 1 clock → err=0.
  - err_clear asserted in the same cycle as the EOW edge of a 0x18 window → err=1.
- PWM/dark:
  - 0x10 high 4 of every 16 clocks → duty=4, pos=4, no error.
  - Whole window 0x00 → duty=0, pos and pos_valid unchanged.
- Saturation: PER_W=4, steps every 32 clocks → step_period=15.
